heu_window_rx: RTL
==================

Name: heu_window_rx

Overview:
- Receive-side endpoint of the IPGU→HEU window interface.
- Accepts 80-pixel beats through the vldIpgu/rdyHeu handshake and assembles 5 beats into one 20x20 window.
- Tags each window with scale index and window X/Y, then presents it to the HEU core through a vld/rdy stage.
- Tracks the scale pyramid: 15, 12, 9, 6 and 1 windows per side.

Parameters:
- BEAT_PIX, 80, pixels per handshake beat.
- WIN_PIX, 400, pixels per window; must be an integer multiple of BEAT_PIX.
- NUM_SCALES, 5, number of pyramid levels.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- frame_start_i  in  1  pulse; clears scale and window counters and drops any partial window
- vld_ipgu_i  in  1  IPGU holding a beat
- ipgu_buf_i  in  8x80  beat pixels; element 0 is the earliest pixel in raster order
- rdy_heu_o  out  1  single-cycle accept pulse to IPGU
- win_vld_o  out  1  assembled window available
- win_rdy_i  in  1  HEU core accepts window
- win_data_o  out  8x400  window pixels, raster order
- win_scale_o  out  3  scale index 0..4
- win_x_o  out  4  window column within scale
- win_y_o  out  4  window row within scale
- win_last_o  out  1  last window of scale 4, i.e. frame done

Behaviour:
- Reset values:
  - all outputs 0; win_data_o 0.
  - State IDLE; beat count, x, y and scale all 0.
- Source protocol:
  - The source deasserts vld combinationally in the cycle it sees rdy.
  - A beat is therefore accepted on the edge ending the cycle where rdy_heu_o=1 and vld_q=1. vld_q is vld_ipgu_i registered one cycle.
  - rdy_heu_o is asserted for exactly one cycle per beat, only when vld_q=1 and vld_ipgu_i=1.
  - ipgu_buf_i is sampled in that same rdy cycle; the source holds data stable while vld is high.
  - rdy_heu_o is never asserted two consecutive cycles.
  - A new beat's rdy requires vld_q to be high again, with minimum 2 cycles between accepts.
- States:
  - IDLE: wait for vld_q&&vld_ipgu_i, then go to COLLECT.
  - COLLECT:
    - Pulse rdy, write beat into slice beat_cnt*BEAT_PIX, increment beat_cnt.
    - At beat_cnt==WIN_PIX/BEAT_PIX-1, accept and go to PRESENT.
    - Otherwise return to waiting; waiting stays in COLLECT with rdy=0.
  - PRESENT:
    - win_vld_o=1. No rdy_heu_o pulses are issued; IPGU is backpressured.
    - On win_vld_o&&win_rdy_i, advance coordinates and go to IDLE.
    - Outputs are held stable while win_vld_o=1 and win_rdy_i=0.
- Coordinate advance, N = {15,12,9,6,1}[scale]:
  - x++; at x==N-1, x=0 and y++.
  - At y==N-1 as well, y=0 and scale++.
  - win_last_o=1 during PRESENT when scale==4, x==0 and y==0.
  - After that window, scale wraps to 0.
- frame_start_i has priority over everything:
  - Next state IDLE; counters cleared; win_vld_o dropped.
  - A beat accepted in the same cycle is discarded.
- Simultaneous events:
  - win handshake and an incoming vld in the same cycle: no accept that cycle; the accept happens in IDLE later.
- Reset mid-beat or mid-window: all progress is lost, with no partial output.
- Scale tag never exceeds 4.

Optional Feature:
- HEU_RX_STATS_EN defined:
  - Adds output win_sum_o, 17 bits: sum of all 400 pixels (max 102000).
  - Adds output win_max_o, 8 bits.
  - Both are accumulated per beat via an adder tree over 80 pixels, registered into the accumulator on each accept.
  - Cleared on entering COLLECT from IDLE.
  - Valid with win_vld_o.
- Undefined: ports absent, no accumulator logic.

Decomposition:
- Package heu_pkg:
  - state_t enum {IDLE, COLLECT, PRESENT}
  - WIN_SIDE=20, BEAT_PIX, WIN_PIX
  - the windows-per-side table as a constant function win_per_side(scale)
- One natural sub-module: heu_win_coord. It holds the x/y/scale counters with inputs adv and clr, and outputs x, y, scale and last.

Test Plan:
- Single window: frame_start, then 5 beats with pixel value = index.
  - Expect exactly 5 rdy pulses, each 1 cycle.
  - Expect win_vld_o with win_data_o[k]=k mod 256, scale 0, x 0, y 0.
- Backpressure: hold win_rdy_i=0 for 50 cycles with vld_ipgu_i=1.
  - Expect no rdy_heu_o pulses and stable win_data_o.
  - Release: 1 handshake, then rdy resumes.
- Full frame: stream 225+144+81+36+1=487 windows.
  - Check the x/y wrap at 14→0 and the scale 0→1 transition at window 225.
  - Check win_last_o only on window 487, and scale returning to 0.
- Source drops vld after its rdy cycle: rdy must not repeat next cycle; the beat is counted once.
- frame_start_i after 3 beats:
  - No window emitted, counters 0.
  - The next 5 beats form window (0,0,0).
- Async reset asserted mid-PRESENT: win_vld_o=0 immediately; state IDLE after release.
- With HEU_RX_STATS_EN, all pixels 255: win_sum_o=102000, win_max_o=255.

Source files
------------

// File: rtl/heu_pkg.sv
// -----------------------------------------------------------------------------
// heu_pkg
// Shared types and constants for the HEU window receive path.
//   state_t       : receive FSM states (IDLE, COLLECT, PRESENT)
//   WIN_SIDE      : window edge length in pixels
//   BEAT_PIX      : pixels carried per IPGU handshake beat
//   WIN_PIX       : pixels per assembled window
//   win_per_side  : windows per side of the scale pyramid for a given scale
// No ports (package).
// -----------------------------------------------------------------------------
package heu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } state_t;

    localparam int WIN_SIDE = 20;
    localparam int BEAT_PIX = 80;
    localparam int WIN_PIX  = WIN_SIDE * WIN_SIDE;

    // Pyramid: 15, 12, 9, 6 and 1 windows per side for scales 0..4.
    function automatic logic [3:0] win_per_side(input logic [2:0] scale);
        logic [3:0] n;
        case (scale)
            3'd0:    n = 4'd15;
            3'd1:    n = 4'd12;
            3'd2:    n = 4'd9;
            3'd3:    n = 4'd6;
            default: n = 4'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/heu_win_coord.sv
// -----------------------------------------------------------------------------
// heu_win_coord
// Window coordinate tracker across the scale pyramid. Walks x then y within a
// scale, then steps to the next scale, wrapping back to scale 0 after the
// single window of the last scale.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   adv_i       : advance to the next window (one per delivered window)
//   clr_i       : clear all counters (has priority over adv_i)
//   x_o, y_o    : window column / row within the current scale
//   scale_o     : current scale index 0..NUM_SCALES-1
//   last_o      : current window is the final window of the frame
// -----------------------------------------------------------------------------
module heu_win_coord
    import heu_pkg::*;
#(
    parameter int NUM_SCALES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adv_i,
    input  logic       clr_i,
    output logic [3:0] x_o,
    output logic [3:0] y_o,
    output logic [2:0] scale_o,
    output logic       last_o
);

    logic [3:0] x_q, x_d;
    logic [3:0] y_q, y_d;
    logic [2:0] scale_q, scale_d;
    logic [3:0] side_max;

    assign side_max = win_per_side(scale_q) - 4'd1;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        scale_d = scale_q;
        if (clr_i) begin
            x_d     = '0;
            y_d     = '0;
            scale_d = '0;
        end else if (adv_i) begin
            if (x_q == side_max) begin
                x_d = '0;
                if (y_q == side_max) begin
                    y_d     = '0;
                    scale_d = (scale_q == 3'(NUM_SCALES - 1)) ? 3'd0 : scale_q + 3'd1;
                end else begin
                    y_d = y_q + 4'd1;
                end
            end else begin
                x_d = x_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            scale_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            scale_q <= scale_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign scale_o = scale_q;
    // The last scale holds a single window, so (0,0) there is the frame end.
    assign last_o  = (scale_q == 3'(NUM_SCALES - 1)) && (x_q == 4'd0) && (y_q == 4'd0);

endmodule

// File: rtl/heu_window_rx.sv
// -----------------------------------------------------------------------------
// heu_window_rx
// Receive endpoint of the IPGU->HEU window interface. Collects WIN_PIX/BEAT_PIX
// beats into one window, tags it with scale/x/y and presents it to the HEU
// core through a vld/rdy stage.
// Optional build macro HEU_RX_STATS_EN adds per-window pixel sum and maximum.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   frame_start_i  : clears counters and drops any partial window
//   vld_ipgu_i     : IPGU holds a beat
//   ipgu_buf_i     : beat pixels, element 0 earliest in raster order
//   rdy_heu_o      : single-cycle beat accept pulse to IPGU
//   win_vld_o      : window available
//   win_rdy_i      : HEU core accepts window
//   win_data_o     : window pixels, raster order
//   win_scale_o    : scale index 0..4
//   win_x_o/y_o    : window column/row within scale
//   win_sum_o      : (HEU_RX_STATS_EN) sum of all window pixels
//   win_max_o      : (HEU_RX_STATS_EN) maximum window pixel
//   win_last_o     : final window of the frame
// -----------------------------------------------------------------------------
module heu_window_rx
    import heu_pkg::*;
#(
    parameter int BEAT_PIX   = heu_pkg::BEAT_PIX,
    parameter int WIN_PIX    = heu_pkg::WIN_PIX,
    parameter int NUM_SCALES = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start_i,
    input  logic                      vld_ipgu_i,
    input  logic [BEAT_PIX-1:0][7:0]  ipgu_buf_i,
    output logic                      rdy_heu_o,
    output logic                      win_vld_o,
    input  logic                      win_rdy_i,
    output logic [WIN_PIX-1:0][7:0]   win_data_o,
    output logic [2:0]                win_scale_o,
    output logic [3:0]                win_x_o,
    output logic [3:0]                win_y_o,
`ifdef HEU_RX_STATS_EN
    output logic [16:0]               win_sum_o,
    output logic [7:0]                win_max_o,
`endif
    output logic                      win_last_o
);

    localparam int BEATS  = WIN_PIX / BEAT_PIX;
    localparam int BCNT_W = $clog2(BEATS + 1);

    state_t                   state_q, state_d;
    logic                     vld_q, vld_d;
    logic [BCNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic [WIN_PIX-1:0][7:0]  win_data_q, win_data_d;
    logic                     beat_avail;
    logic                     win_hs;
    logic                     coord_last;

    // A beat is offered once vld has been seen on two consecutive cycles.
    assign beat_avail = vld_q && vld_ipgu_i;
    assign win_hs     = (state_q == PRESENT) && win_rdy_i;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        win_data_d = win_data_q;
        rdy_heu_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (beat_avail) state_d = COLLECT;
            end
            COLLECT: begin
                if (beat_avail) begin
                    rdy_heu_o = 1'b1;
                    for (int b = 0; b < BEATS; b++) begin
                        if (beat_cnt_q == BCNT_W'(b))
                            win_data_d[b*BEAT_PIX +: BEAT_PIX] = ipgu_buf_i;
                    end
                    if (beat_cnt_q == BCNT_W'(BEATS - 1)) begin
                        state_d    = PRESENT;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCNT_W'(1);
                    end
                end
            end
            PRESENT: begin
                if (win_rdy_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Frame start wins over everything, including a beat taken this cycle.
        if (frame_start_i) begin
            state_d    = IDLE;
            beat_cnt_d = '0;
            win_data_d = win_data_q;
        end
    end

    // Clearing the registered vld on accept forces a fresh vld sample before
    // the next rdy, so rdy can never fire on back-to-back cycles.
    assign vld_d = vld_ipgu_i && !rdy_heu_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vld_q      <= 1'b0;
            beat_cnt_q <= '0;
            win_data_q <= '0;
        end else begin
            state_q    <= state_d;
            vld_q      <= vld_d;
            beat_cnt_q <= beat_cnt_d;
            win_data_q <= win_data_d;
        end
    end

    heu_win_coord #(
        .NUM_SCALES (NUM_SCALES)
    ) u_coord (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (win_hs),
        .clr_i   (frame_start_i),
        .x_o     (win_x_o),
        .y_o     (win_y_o),
        .scale_o (win_scale_o),
        .last_o  (coord_last)
    );

    assign win_vld_o  = (state_q == PRESENT);
    assign win_data_o = win_data_q;
    assign win_last_o = (state_q == PRESENT) && coord_last;

`ifdef HEU_RX_STATS_EN
    logic [16:0] sum_q;
    logic [7:0]  max_q;
    logic [16:0] beat_sum;
    logic [7:0]  beat_max;
    logic        accept;
    logic        stats_clr;

    assign accept    = rdy_heu_o && !frame_start_i;
    assign stats_clr = (state_q == IDLE) && beat_avail && !frame_start_i;

    always_comb begin
        beat_sum = '0;
        beat_max = '0;
        for (int i = 0; i < BEAT_PIX; i++) begin
            beat_sum = beat_sum + 17'(ipgu_buf_i[i]);
            if (ipgu_buf_i[i] > beat_max) beat_max = ipgu_buf_i[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            max_q <= '0;
        end else if (stats_clr) begin
            sum_q <= '0;
            max_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + beat_sum;
            max_q <= (beat_max > max_q) ? beat_max : max_q;
        end
    end

    assign win_sum_o = sum_q;
    assign win_max_o = max_q;
`endif

endmodule
